// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_arb_pkg
// Description : Shared types and the round-robin winner search used by the
//               address-channel grant FSMs of axi_master_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int RR_MAX_W = 5;
    localparam int RR_MAX_N = 2**RR_MAX_W;

    // First set bit of req searching upward from last+1, wrapping at n.
    function automatic logic [RR_MAX_W-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] req,
        input logic [RR_MAX_W-1:0] last,
        input int unsigned         n
    );
        logic [RR_MAX_W-1:0] win;
        logic                found;
        int unsigned         idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
            idx = (32'(last) + i) % n;
            if (i <= n && !found && req[idx[RR_MAX_W-1:0]]) begin
                win   = idx[RR_MAX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_arbiter_if
// Description : Request, observed-handshake and select/enable signals between
//               axi_master_arbiter and the surrounding switch.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_master_arbiter_if #(
    parameter int M_WIDTH = 2,
    parameter int M_ID    = 2
);
    logic [2**M_WIDTH-1:0]    MASTER_WR_ADDR_VALID;
    logic [2**M_WIDTH-1:0]    MASTER_RD_ADDR_VALID;
    logic                     BUS_WR_ADDR_VALID;
    logic                     BUS_WR_ADDR_READY;
    logic                     BUS_WR_DATA_VALID;
    logic                     BUS_WR_DATA_READY;
    logic                     BUS_WR_DATA_LAST;
    logic                     BUS_RD_ADDR_VALID;
    logic                     BUS_RD_ADDR_READY;
    logic [M_ID+M_WIDTH-1:0]  BUS_WR_BACK_ID;
    logic [M_ID+M_WIDTH-1:0]  BUS_RD_BACK_ID;

    logic [M_WIDTH-1:0]       wr_addr_sel;
    logic [M_WIDTH-1:0]       wr_data_sel;
    logic [M_WIDTH-1:0]       wr_resp_sel;
    logic [M_WIDTH-1:0]       rd_addr_sel;
    logic [M_WIDTH-1:0]       rd_data_sel;
    logic                     wr_addr_en;
    logic                     wr_data_en;
    logic                     rd_addr_en;
    logic                     wfifo_full;
    logic                     wfifo_empty;

    modport slave (
        input  MASTER_WR_ADDR_VALID, MASTER_RD_ADDR_VALID,
        input  BUS_WR_ADDR_VALID, BUS_WR_ADDR_READY,
        input  BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST,
        input  BUS_RD_ADDR_VALID, BUS_RD_ADDR_READY,
        input  BUS_WR_BACK_ID, BUS_RD_BACK_ID,
        output wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel,
        output wr_addr_en, wr_data_en, rd_addr_en,
        output wfifo_full, wfifo_empty
    );

    modport master (
        output MASTER_WR_ADDR_VALID, MASTER_RD_ADDR_VALID,
        output BUS_WR_ADDR_VALID, BUS_WR_ADDR_READY,
        output BUS_WR_DATA_VALID, BUS_WR_DATA_READY, BUS_WR_DATA_LAST,
        output BUS_RD_ADDR_VALID, BUS_RD_ADDR_READY,
        output BUS_WR_BACK_ID, BUS_RD_BACK_ID,
        input  wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel,
        input  wr_addr_en, wr_data_en, rd_addr_en,
        input  wfifo_full, wfifo_empty
    );
endinterface
`default_nettype wire

// File: rtl/axi_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : axi_rr_grant
// Description : Round-robin grant FSM for one address channel; holds the
//               grant until the bus handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rr_grant
    import axi_arb_pkg::*;
#(
    parameter int M_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2**M_WIDTH-1:0] i_req,
    input  logic                  i_allow,
    input  logic                  i_hs,
    output logic [M_WIDTH-1:0]    o_sel,
    output logic                  o_en
);

    localparam int unsigned N = 2**M_WIDTH;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [M_WIDTH-1:0]   r_sel;
    logic [M_WIDTH-1:0]   w_sel_nxt;
    logic [M_WIDTH-1:0]   r_last;
    logic [M_WIDTH-1:0]   w_last_nxt;
    logic [RR_MAX_W-1:0]  w_pick;

    assign w_pick = rr_pick(RR_MAX_N'(i_req), RR_MAX_W'(r_last), N);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        case (r_state)
            ARB_IDLE: begin
                if ((|i_req) && i_allow) begin
                    w_state_nxt = ARB_LOCK;
                    w_sel_nxt   = w_pick[M_WIDTH-1:0];
                end
            end
            ARB_LOCK: begin
                // Only the bus handshake releases; a withdrawn VALID does not.
                if (i_hs) begin
                    w_state_nxt = ARB_IDLE;
                    w_last_nxt  = r_sel;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ARB_IDLE;
            r_sel   <= '0;
            r_last  <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign o_sel = r_sel;
    assign o_en  = (r_state == ARB_LOCK);

endmodule
`default_nettype wire

// File: rtl/axi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_arbiter
// Description : Sequencing controller for axi_master_switch: round-robin AW/AR
//               grants, write-order FIFO for W, ID-based B/R return routing.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int M_WIDTH     = 2,
    parameter int M_ID        = 2,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_master_arbiter_if.slave  arb_if
);

    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [M_WIDTH-1:0] r_fifo [WFIFO_DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic [M_WIDTH-1:0] w_wr_addr_sel;
    logic [M_WIDTH-1:0] w_rd_addr_sel;
    logic               w_wr_addr_en;
    logic               w_rd_addr_en;
    logic               w_aw_hs;
    logic               w_ar_hs;
    logic               w_w_last_hs;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    assign w_full  = (r_count == CW'(WFIFO_DEPTH));
    assign w_empty = (r_count == '0);

    assign w_aw_hs     = arb_if.BUS_WR_ADDR_VALID & arb_if.BUS_WR_ADDR_READY & w_wr_addr_en;
    assign w_ar_hs     = arb_if.BUS_RD_ADDR_VALID & arb_if.BUS_RD_ADDR_READY & w_rd_addr_en;
    assign w_w_last_hs = arb_if.BUS_WR_DATA_VALID & arb_if.BUS_WR_DATA_READY & arb_if.BUS_WR_DATA_LAST;

    // W with no accepted AW ahead of it is never passed, so an empty FIFO cannot pop.
    assign w_pop  = w_w_last_hs & ~w_empty;
    assign w_push = w_aw_hs & (~w_full | w_pop);

    axi_rr_grant #(
        .M_WIDTH (M_WIDTH)
    ) u_aw_grant (
        .clk     (clk),
        .rstn    (rstn),
        .i_req   (arb_if.MASTER_WR_ADDR_VALID),
        .i_allow (~w_full),
        .i_hs    (w_aw_hs),
        .o_sel   (w_wr_addr_sel),
        .o_en    (w_wr_addr_en)
    );

    axi_rr_grant #(
        .M_WIDTH (M_WIDTH)
    ) u_ar_grant (
        .clk     (clk),
        .rstn    (rstn),
        .i_req   (arb_if.MASTER_RD_ADDR_VALID),
        .i_allow (1'b1),
        .i_hs    (w_ar_hs),
        .o_sel   (w_rd_addr_sel),
        .o_en    (w_rd_addr_en)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_wr_addr_sel;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign arb_if.wr_addr_sel = w_wr_addr_sel;
    assign arb_if.wr_addr_en  = w_wr_addr_en;
    assign arb_if.rd_addr_sel = w_rd_addr_sel;
    assign arb_if.rd_addr_en  = w_rd_addr_en;
    assign arb_if.wr_data_sel = w_empty ? '0 : r_fifo[r_rptr];
    assign arb_if.wr_data_en  = ~w_empty;
    assign arb_if.wfifo_full  = w_full;
    assign arb_if.wfifo_empty = w_empty;
    assign arb_if.wr_resp_sel = arb_if.BUS_WR_BACK_ID[M_ID+M_WIDTH-1:M_ID];
    assign arb_if.rd_data_sel = arb_if.BUS_RD_BACK_ID[M_ID+M_WIDTH-1:M_ID];

endmodule
`default_nettype wire

// File: tb/tb_axi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_master_arbiter
// Description : Self-checking bench for axi_master_arbiter (directed scenarios
//               plus randomized traffic against a queue-based reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_master_arbiter;

    localparam int M_WIDTH = 2;
    localparam int M_ID    = 2;
    localparam int DEPTH   = 4;
    localparam int NM      = 2**M_WIDTH;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    axi_master_arbiter_if #(.M_WIDTH(M_WIDTH), .M_ID(M_ID)) ifc ();

    axi_master_arbiter #(
        .M_WIDTH     (M_WIDTH),
        .M_ID        (M_ID),
        .WFIFO_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .arb_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        ifc.MASTER_WR_ADDR_VALID = '0;
        ifc.MASTER_RD_ADDR_VALID = '0;
        ifc.BUS_WR_ADDR_VALID    = 1'b0;
        ifc.BUS_WR_ADDR_READY    = 1'b0;
        ifc.BUS_WR_DATA_VALID    = 1'b0;
        ifc.BUS_WR_DATA_READY    = 1'b0;
        ifc.BUS_WR_DATA_LAST     = 1'b0;
        ifc.BUS_RD_ADDR_VALID    = 1'b0;
        ifc.BUS_RD_ADDR_READY    = 1'b0;
        ifc.BUS_WR_BACK_ID       = '0;
        ifc.BUS_RD_BACK_ID       = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic set_aw_hs(input logic v);
        ifc.BUS_WR_ADDR_VALID = v;
        ifc.BUS_WR_ADDR_READY = v;
    endtask

    task automatic set_w_hs(input logic v, input logic last);
        ifc.BUS_WR_DATA_VALID = v;
        ifc.BUS_WR_DATA_READY = v;
        ifc.BUS_WR_DATA_LAST  = last;
    endtask

    // Reference round-robin: first requester above 'last', wrapping.
    function automatic int rr_ref(input int req, input int last);
        for (int k = 1; k <= NM; k++) begin
            int m;
            m = (last + k) % NM;
            if (((req >> m) & 1) == 1) return m;
        end
        return 0;
    endfunction

    task automatic test_reset;
        clear_inputs();
        rstn = 1'b0;
        #1;
        checks++;
        if (ifc.wr_addr_en !== 1'b0 || ifc.rd_addr_en !== 1'b0 || ifc.wr_data_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_en: aw=%b ar=%b w=%b expected all 0", ifc.wr_addr_en, ifc.rd_addr_en, ifc.wr_data_en);
        end
        checks++;
        if (ifc.wr_addr_sel !== 2'd0 || ifc.rd_addr_sel !== 2'd0 || ifc.wr_data_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_sel: aw=%0d ar=%0d w=%0d expected all 0", ifc.wr_addr_sel, ifc.rd_addr_sel, ifc.wr_data_sel);
        end
        checks++;
        if (ifc.wfifo_empty !== 1'b1 || ifc.wfifo_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo: empty=%b full=%b expected empty=1 full=0", ifc.wfifo_empty, ifc.wfifo_full);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_rr_all;
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        ifc.MASTER_WR_ADDR_VALID = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ifc.wr_addr_en !== 1'b1 || ifc.wr_addr_sel !== exp_seq[k]) begin
                errors++;
                $display("FAIL rr_all_grant%0d: en=%b sel=%0d expected en=1 sel=%0d", k, ifc.wr_addr_en, ifc.wr_addr_sel, exp_seq[k]);
            end
            set_aw_hs(1'b1);
            tick();
            set_aw_hs(1'b0);
            checks++;
            if (ifc.wr_addr_en !== 1'b0) begin
                errors++;
                $display("FAIL rr_all_gap%0d: en=%b expected 0", k, ifc.wr_addr_en);
            end
            checks++;
            if (ifc.wr_data_en !== 1'b1 || ifc.wr_data_sel !== exp_seq[k]) begin
                errors++;
                $display("FAIL rr_all_wdata%0d: en=%b sel=%0d expected en=1 sel=%0d", k, ifc.wr_data_en, ifc.wr_data_sel, exp_seq[k]);
            end
            set_w_hs(1'b1, 1'b1);
            tick();
            set_w_hs(1'b0, 1'b0);
        end
        clear_inputs();
    endtask

    task automatic test_wrap;
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
        do_reset();
        ifc.MASTER_WR_ADDR_VALID = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ifc.wr_addr_en !== 1'b1 || ifc.wr_addr_sel !== exp_seq[k]) begin
                errors++;
                $display("FAIL wrap_grant%0d: en=%b sel=%0d expected en=1 sel=%0d", k, ifc.wr_addr_en, ifc.wr_addr_sel, exp_seq[k]);
            end
            if (k == 2) ifc.MASTER_WR_ADDR_VALID = 4'b0101;
            set_aw_hs(1'b1);
            tick();
            set_aw_hs(1'b0);
            set_w_hs(1'b1, 1'b1);
            tick();
            set_w_hs(1'b0, 1'b0);
        end
        clear_inputs();
    endtask

    task automatic test_fifo_full;
        logic [1:0] order [4];
        order = '{2'd3, 2'd1, 2'd1, 2'd2};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ifc.MASTER_WR_ADDR_VALID = 4'(1 << order[k]);
            tick();
            checks++;
            if (ifc.wr_addr_en !== 1'b1 || ifc.wr_addr_sel !== order[k]) begin
                errors++;
                $display("FAIL full_grant%0d: en=%b sel=%0d expected en=1 sel=%0d", k, ifc.wr_addr_en, ifc.wr_addr_sel, order[k]);
            end
            set_aw_hs(1'b1);
            tick();
            set_aw_hs(1'b0);
        end
        checks++;
        if (ifc.wfifo_full !== 1'b1 || ifc.wfifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flag: full=%b empty=%b expected full=1 empty=0", ifc.wfifo_full, ifc.wfifo_empty);
        end
        ifc.MASTER_WR_ADDR_VALID = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ifc.wr_addr_en !== 1'b0) begin
                errors++;
                $display("FAIL full_block%0d: wr_addr_en=%b expected 0", c, ifc.wr_addr_en);
            end
        end
        // A non-LAST beat must not release the head.
        set_w_hs(1'b1, 1'b0);
        tick();
        set_w_hs(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ifc.wr_data_en !== 1'b1 || ifc.wr_data_sel !== order[k]) begin
                errors++;
                $display("FAIL full_head%0d: en=%b sel=%0d expected en=1 sel=%0d", k, ifc.wr_data_en, ifc.wr_data_sel, order[k]);
            end
            set_w_hs(1'b1, 1'b1);
            tick();
            set_w_hs(1'b0, 1'b0);
        end
        checks++;
        if (ifc.wfifo_empty !== 1'b1 || ifc.wr_data_en !== 1'b0 || ifc.wr_data_sel !== 2'd0) begin
            errors++;
            $display("FAIL full_drain: empty=%b en=%b sel=%0d expected 1 0 0", ifc.wfifo_empty, ifc.wr_data_en, ifc.wr_data_sel);
        end
        checks++;
        if (ifc.wr_addr_en !== 1'b1 || ifc.wr_addr_sel !== 2'd0) begin
            errors++;
            $display("FAIL full_fifth: en=%b sel=%0d expected en=1 sel=0", ifc.wr_addr_en, ifc.wr_addr_sel);
        end
        clear_inputs();
    endtask

    task automatic test_simul_push_pop;
        logic [1:0] order [3];
        order = '{2'd1, 2'd2, 2'd3};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            ifc.MASTER_WR_ADDR_VALID = 4'(1 << order[k]);
            tick();
            set_aw_hs(1'b1);
            tick();
            set_aw_hs(1'b0);
        end
        ifc.MASTER_WR_ADDR_VALID = 4'b1000;
        tick();
        checks++;
        if (ifc.wr_addr_en !== 1'b1 || ifc.wr_addr_sel !== 2'd3 || ifc.wr_data_sel !== 2'd1) begin
            errors++;
            $display("FAIL simul_pre: en=%b aw_sel=%0d w_sel=%0d expected 1 3 1", ifc.wr_addr_en, ifc.wr_addr_sel, ifc.wr_data_sel);
        end
        ifc.MASTER_WR_ADDR_VALID = '0;
        set_aw_hs(1'b1);
        set_w_hs(1'b1, 1'b1);
        tick();
        set_aw_hs(1'b0);
        set_w_hs(1'b0, 1'b0);
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (ifc.wr_data_en !== 1'b1 || ifc.wr_data_sel !== order[k]) begin
                errors++;
                $display("FAIL simul_head%0d: en=%b sel=%0d expected en=1 sel=%0d", k, ifc.wr_data_en, ifc.wr_data_sel, order[k]);
            end
            set_w_hs(1'b1, 1'b1);
            tick();
            set_w_hs(1'b0, 1'b0);
        end
        checks++;
        if (ifc.wfifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_empty: empty=%b expected 1", ifc.wfifo_empty);
        end
        clear_inputs();
    endtask

    task automatic test_resp_route;
        ifc.BUS_WR_BACK_ID = 4'b1011;
        ifc.BUS_RD_BACK_ID = 4'b0110;
        #1;
        checks++;
        if (ifc.wr_resp_sel !== 2'd2 || ifc.rd_data_sel !== 2'd1) begin
            errors++;
            $display("FAIL route_fixed: b=%0d r=%0d expected b=2 r=1", ifc.wr_resp_sel, ifc.rd_data_sel);
        end
        for (int k = 0; k < 8; k++) begin
            int bid;
            int rid;
            bid = int'($urandom_range(0, 15));
            rid = int'($urandom_range(0, 15));
            ifc.BUS_WR_BACK_ID = 4'(bid);
            ifc.BUS_RD_BACK_ID = 4'(rid);
            #1;
            checks++;
            if (ifc.wr_resp_sel !== 2'(bid / (2**M_ID)) || ifc.rd_data_sel !== 2'(rid / (2**M_ID))) begin
                errors++;
                $display("FAIL route_rand%0d: b=%0d r=%0d expected b=%0d r=%0d", k, ifc.wr_resp_sel, ifc.rd_data_sel, bid / (2**M_ID), rid / (2**M_ID));
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_async_reset;
        do_reset();
        ifc.MASTER_RD_ADDR_VALID = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            ifc.MASTER_WR_ADDR_VALID = 4'(1 << k);
            tick();
            set_aw_hs(1'b1);
            tick();
            set_aw_hs(1'b0);
        end
        ifc.MASTER_WR_ADDR_VALID = 4'b1000;
        tick();
        checks++;
        if (ifc.wr_addr_en !== 1'b1 || ifc.rd_addr_en !== 1'b1 || ifc.wfifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL areset_pre: aw_en=%b ar_en=%b empty=%b expected 1 1 0", ifc.wr_addr_en, ifc.rd_addr_en, ifc.wfifo_empty);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (ifc.wr_addr_en !== 1'b0 || ifc.rd_addr_en !== 1'b0 || ifc.wr_data_en !== 1'b0) begin
            errors++;
            $display("FAIL areset_en: aw=%b ar=%b w=%b expected all 0", ifc.wr_addr_en, ifc.rd_addr_en, ifc.wr_data_en);
        end
        checks++;
        if (ifc.wr_addr_sel !== 2'd0 || ifc.rd_addr_sel !== 2'd0 || ifc.wfifo_empty !== 1'b1 || ifc.wfifo_full !== 1'b0) begin
            errors++;
            $display("FAIL areset_state: aw_sel=%0d ar_sel=%0d empty=%b full=%b expected 0 0 1 0",
                     ifc.wr_addr_sel, ifc.rd_addr_sel, ifc.wfifo_empty, ifc.wfifo_full);
        end
        @(negedge clk);
        clear_inputs();
        rstn = 1'b1;
        ifc.MASTER_WR_ADDR_VALID = 4'b1111;
        tick();
        checks++;
        if (ifc.wr_addr_en !== 1'b1 || ifc.wr_addr_sel !== 2'd0) begin
            errors++;
            $display("FAIL areset_next: en=%b sel=%0d expected en=1 sel=0", ifc.wr_addr_en, ifc.wr_addr_sel);
        end
        clear_inputs();
    endtask

    task automatic test_random;
        int aw_lock, aw_sel, aw_last;
        int ar_lock, ar_sel, ar_last;
        int q[$];
        int exp_head;
        do_reset();
        aw_lock = 0; aw_sel = 0; aw_last = NM - 1;
        ar_lock = 0; ar_sel = 0; ar_last = NM - 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int wreq, rreq, awhs, arhs, pop;
            exp_head = (q.size() > 0) ? q[0] : 0;
            checks++;
            if (ifc.wr_addr_en !== 1'(aw_lock) || ifc.wr_addr_sel !== 2'(aw_sel)) begin
                errors++;
                $display("FAIL rand_aw c%0d: en=%b sel=%0d expected en=%0d sel=%0d", cyc, ifc.wr_addr_en, ifc.wr_addr_sel, aw_lock, aw_sel);
            end
            checks++;
            if (ifc.rd_addr_en !== 1'(ar_lock) || ifc.rd_addr_sel !== 2'(ar_sel)) begin
                errors++;
                $display("FAIL rand_ar c%0d: en=%b sel=%0d expected en=%0d sel=%0d", cyc, ifc.rd_addr_en, ifc.rd_addr_sel, ar_lock, ar_sel);
            end
            checks++;
            if (ifc.wr_data_en !== 1'(q.size() > 0) || ifc.wr_data_sel !== 2'(exp_head) ||
                ifc.wfifo_full !== 1'(q.size() == DEPTH) || ifc.wfifo_empty !== 1'(q.size() == 0)) begin
                errors++;
                $display("FAIL rand_fifo c%0d: en=%b sel=%0d full=%b empty=%b expected count=%0d head=%0d",
                         cyc, ifc.wr_data_en, ifc.wr_data_sel, ifc.wfifo_full, ifc.wfifo_empty, q.size(), exp_head);
            end
            wreq = int'($urandom_range(0, 15));
            rreq = int'($urandom_range(0, 15));
            awhs = (aw_lock == 1 && $urandom_range(0, 2) != 0) ? 1 : 0;
            arhs = (ar_lock == 1 && $urandom_range(0, 2) != 0) ? 1 : 0;
            ifc.MASTER_WR_ADDR_VALID = 4'(wreq);
            ifc.MASTER_RD_ADDR_VALID = 4'(rreq);
            ifc.BUS_WR_ADDR_VALID    = 1'(awhs);
            ifc.BUS_WR_ADDR_READY    = 1'(awhs);
            ifc.BUS_RD_ADDR_VALID    = 1'(arhs);
            ifc.BUS_RD_ADDR_READY    = 1'(arhs);
            ifc.BUS_WR_DATA_VALID    = 1'(q.size() > 0 && $urandom_range(0, 1) == 1);
            ifc.BUS_WR_DATA_READY    = 1'($urandom_range(0, 3) != 0);
            ifc.BUS_WR_DATA_LAST     = 1'($urandom_range(0, 1));
            pop = (ifc.BUS_WR_DATA_VALID && ifc.BUS_WR_DATA_READY && ifc.BUS_WR_DATA_LAST && q.size() > 0) ? 1 : 0;
            if (aw_lock == 0) begin
                if (wreq != 0 && q.size() < DEPTH) begin
                    aw_sel  = rr_ref(wreq, aw_last);
                    aw_lock = 1;
                end
            end else if (awhs == 1) begin
                aw_lock = 0;
                aw_last = aw_sel;
            end
            if (ar_lock == 0) begin
                if (rreq != 0) begin
                    ar_sel  = rr_ref(rreq, ar_last);
                    ar_lock = 1;
                end
            end else if (arhs == 1) begin
                ar_lock = 0;
                ar_last = ar_sel;
            end
            if (pop == 1) void'(q.pop_front());
            if (awhs == 1) q.push_back(aw_sel);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_rr_all();
        test_wrap();
        test_fifo_full();
        test_simul_push_pop();
        test_resp_route();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
